// File: rtl/toggle_period_checker.sv
// toggle_period_checker: measures the clock count between edges of an
// asynchronous toggling input, flags in-tolerance periods, tracks lock and
// reports a stalled input by timeout.
module toggle_period_checker #(
  parameter int unsigned COUNT_LIMIT = 10,
  parameter int unsigned TOLERANCE   = 0,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TIMEOUT     = 4 * COUNT_LIMIT,
  parameter int unsigned CNT_W       = $clog2(TIMEOUT + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Enable,
  input  logic             i_Toggle,
  output logic [CNT_W-1:0] o_Period,
  output logic             o_Valid,
  output logic             o_Match,
  output logic             o_Locked,
  output logic             o_Timeout
);

  localparam int unsigned LOCK_W   = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MATCH_LO = COUNT_LIMIT - TOLERANCE;
  localparam int unsigned MATCH_HI = COUNT_LIMIT + TOLERANCE;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_COUNT);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [LOCK_W-1:0]  r_lock_cnt, w_lock_cnt_nxt;
  logic [CNT_W-1:0]   w_period_nxt;
  logic               w_valid_nxt, w_match_nxt, w_locked_nxt, w_timeout_nxt;
  logic               r_sync1, r_sync2, r_prev;
  logic               w_edge, w_in_tol;
  logic [LOCK_W-1:0]  w_lock_inc;

  // Input synchronizer and previous-value register for edge detection
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_Toggle;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge     = r_sync2 ^ r_prev;
  assign w_in_tol   = (32'(r_count) >= MATCH_LO) && (32'(r_count) <= MATCH_HI);
  assign w_lock_inc = (r_lock_cnt == LOCK_MAX) ? LOCK_MAX : r_lock_cnt + LOCK_W'(1);

  // State, counters and registered outputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_lock_cnt <= '0;
      o_Period   <= '0;
      o_Valid    <= 1'b0;
      o_Match    <= 1'b0;
      o_Locked   <= 1'b0;
      o_Timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      o_Period   <= w_period_nxt;
      o_Valid    <= w_valid_nxt;
      o_Match    <= w_match_nxt;
      o_Locked   <= w_locked_nxt;
      o_Timeout  <= w_timeout_nxt;
    end
  end

  // Next-state and output decode; enable beats edge, edge beats timeout
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_lock_cnt_nxt = r_lock_cnt;
    w_period_nxt   = o_Period;
    w_valid_nxt    = 1'b0;
    w_match_nxt    = o_Match;
    w_locked_nxt   = o_Locked;
    w_timeout_nxt  = 1'b0;

    if (!i_Enable) begin
      w_state_nxt    = IDLE;
      w_count_nxt    = '0;
      w_lock_cnt_nxt = '0;
      w_match_nxt    = 1'b0;
      w_locked_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_count_nxt = '0;
          if (w_edge) begin
            // First edge only starts the measurement
            w_count_nxt = CNT_W'(1);
            w_state_nxt = MEASURE;
          end
        end
        MEASURE: begin
          if (w_edge) begin
            w_period_nxt = r_count;
            w_valid_nxt  = 1'b1;
            w_match_nxt  = w_in_tol;
            w_count_nxt  = CNT_W'(1);
            if (w_in_tol) begin
              w_lock_cnt_nxt = w_lock_inc;
              if (w_lock_inc == LOCK_MAX) begin
                w_locked_nxt = 1'b1;
              end
            end else begin
              w_lock_cnt_nxt = '0;
              w_locked_nxt   = 1'b0;
            end
          end else if (r_count == CNT_MAX) begin
            w_timeout_nxt  = 1'b1;
            w_lock_cnt_nxt = '0;
            w_locked_nxt   = 1'b0;
            w_match_nxt    = 1'b0;
            w_count_nxt    = '0;
            w_state_nxt    = IDLE;
          end else begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_period_checker.sv
// Bench for toggle_period_checker: two instances (tolerance 0 and 1) share the
// stimulus; an event-level model predicts every valid/timeout pulse.
module tb_toggle_period_checker;

  localparam int unsigned LIMIT   = 10;
  localparam int unsigned LOCKN   = 4;
  localparam int unsigned TMO     = 4 * LIMIT;
  localparam int unsigned CW      = $clog2(TMO + 1);
  localparam int          LAT     = 3;

  logic          i_Clk = 1'b0;
  logic          i_Rst;
  logic          i_Enable;
  logic          i_Toggle;
  logic [CW-1:0] period0, period1;
  logic          valid0, valid1, match0, match1, locked0, locked1, tmo0, tmo1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] dq0[$], dq1[$], eq0[$], eq1[$];

  // Model state per instance
  int tol[2] = '{0, 1};
  int m_active[2];
  int m_last[2];
  int m_matches[2];
  int m_period[2];

  toggle_period_checker #(.COUNT_LIMIT(LIMIT), .TOLERANCE(0), .LOCK_COUNT(LOCKN)) dut0 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable), .i_Toggle(i_Toggle),
    .o_Period(period0), .o_Valid(valid0), .o_Match(match0), .o_Locked(locked0),
    .o_Timeout(tmo0)
  );

  toggle_period_checker #(.COUNT_LIMIT(LIMIT), .TOLERANCE(1), .LOCK_COUNT(LOCKN)) dut1 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable), .i_Toggle(i_Toggle),
    .o_Period(period1), .o_Valid(valid1), .o_Match(match1), .o_Locked(locked1),
    .o_Timeout(tmo1)
  );

  always #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) cyc <= cyc + 1;

  // Collect DUT pulses as {kind, cycle, period, match, locked}
  always @(negedge i_Clk) begin
    if (valid0 || tmo0)
      dq0.push_back({8'(valid0 ? 1 : 2), 32'(cyc), 16'(period0), 4'(match0), 4'(locked0)});
    if (valid1 || tmo1)
      dq1.push_back({8'(valid1 ? 1 : 2), 32'(cyc), 16'(period1), 4'(match1), 4'(locked1)});
  end

  function automatic void push_exp(input int d, input logic [63:0] e);
    if (d == 0) eq0.push_back(e);
    else        eq1.push_back(e);
  endfunction

  function automatic int pending(input int d);
    return (d == 0) ? (dq0.size() + eq0.size()) : (dq1.size() + eq1.size());
  endfunction

  function automatic void pop_pair(input int d, output logic [63:0] a, output logic [63:0] e);
    a = '1;
    e = '1;
    if (d == 0) begin
      if (dq0.size() != 0) a = dq0.pop_front();
      if (eq0.size() != 0) e = eq0.pop_front();
    end else begin
      if (dq1.size() != 0) a = dq1.pop_front();
      if (eq1.size() != 0) e = eq1.pop_front();
    end
  endfunction

  // Model: an input toggle seen at cycle t
  function automatic void model_edge(input int t);
    int   gap;
    logic m;
    for (int d = 0; d < 2; d++) begin
      if (m_active[d] == 0) begin
        m_active[d] = 1;
        m_last[d]   = t;
      end else begin
        gap = t - m_last[d];
        if (gap > int'(TMO)) begin
          push_exp(d, {8'(2), 32'(m_last[d] + LAT + int'(TMO)), 16'(m_period[d]), 4'(0), 4'(0)});
          m_matches[d] = 0;
        end else begin
          m = (gap >= int'(LIMIT) - tol[d]) && (gap <= int'(LIMIT) + tol[d]);
          m_matches[d] = m ? m_matches[d] + 1 : 0;
          m_period[d]  = gap;
          push_exp(d, {8'(1), 32'(t + LAT), 16'(gap), 4'(m), 4'(m_matches[d] >= int'(LOCKN))});
        end
        m_last[d] = t;
      end
    end
  endfunction

  // Model: input has been quiet long enough for any open measurement to time out
  function automatic void model_flush();
    for (int d = 0; d < 2; d++) begin
      if (m_active[d] != 0) begin
        push_exp(d, {8'(2), 32'(m_last[d] + LAT + int'(TMO)), 16'(m_period[d]), 4'(0), 4'(0)});
        m_matches[d] = 0;
        m_active[d]  = 0;
      end
    end
  endfunction

  function automatic void model_disable();
    for (int d = 0; d < 2; d++) begin
      m_active[d]  = 0;
      m_matches[d] = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_active[d]  = 0;
      m_matches[d] = 0;
      m_period[d]  = 0;
    end
  endfunction

  task automatic toggle_after(input int n);
    repeat (n) @(negedge i_Clk);
    i_Toggle = ~i_Toggle;
    model_edge(cyc);
  endtask

  task automatic quiet_flush();
    repeat (TMO + 8) @(negedge i_Clk);
    model_flush();
  endtask

  task automatic test_reset();
    logic [63:0] a, e;
    i_Rst = 1'b1; i_Enable = 1'b1; i_Toggle = 1'b0;
    model_reset();
    repeat (3) @(negedge i_Clk);
    checks += 10;
    if (period0 !== '0) begin errors++; $display("FAIL reset period0: got %0d expected 0", period0); end
    if (period1 !== '0) begin errors++; $display("FAIL reset period1: got %0d expected 0", period1); end
    if ({valid0, match0, locked0, tmo0} !== 4'b0) begin errors++; $display("FAIL reset flags0: got %b expected 0000", {valid0, match0, locked0, tmo0}); end
    if ({valid1, match1, locked1, tmo1} !== 4'b0) begin errors++; $display("FAIL reset flags1: got %b expected 0000", {valid1, match1, locked1, tmo1}); end
    if (valid0 !== 1'b0) begin errors++; $display("FAIL reset valid0: got %b expected 0", valid0); end
    if (valid1 !== 1'b0) begin errors++; $display("FAIL reset valid1: got %b expected 0", valid1); end
    if (locked0 !== 1'b0) begin errors++; $display("FAIL reset locked0: got %b expected 0", locked0); end
    if (locked1 !== 1'b0) begin errors++; $display("FAIL reset locked1: got %b expected 0", locked1); end
    if (tmo0 !== 1'b0) begin errors++; $display("FAIL reset tmo0: got %b expected 0", tmo0); end
    if (tmo1 !== 1'b0) begin errors++; $display("FAIL reset tmo1: got %b expected 0", tmo1); end
    i_Rst = 1'b0;
    repeat (4) @(negedge i_Clk);
    for (int d = 0; d < 2; d++)
      while (pending(d) != 0) begin
        pop_pair(d, a, e); checks++;
        if (a !== e) begin errors++; $display("FAIL reset_quiet dut%0d event: got %h expected %h", d, a, e); end
      end
  endtask

  // Lock on nominal period, lose it on a long period, relock, then tolerance cases
  task automatic test_lock_and_tolerance();
    logic [63:0] a, e;
    int gaps[] = '{10, 10, 10, 10, 10, 12, 10, 10, 10, 10, 9, 11, 10, 11, 8};
    toggle_after(2);
    foreach (gaps[i]) toggle_after(gaps[i]);
    quiet_flush();
    for (int d = 0; d < 2; d++)
      while (pending(d) != 0) begin
        pop_pair(d, a, e); checks++;
        if (a !== e) begin errors++; $display("FAIL lock_tol dut%0d event: got %h expected %h", d, a, e); end
      end
  endtask

  // Timeout boundary: a gap of exactly TIMEOUT measures, one more times out
  task automatic test_timeout();
    logic [63:0] a, e;
    int gaps[] = '{10, 10, 10, 10, 40, 41, 10};
    toggle_after(3);
    foreach (gaps[i]) toggle_after(gaps[i]);
    quiet_flush();
    toggle_after(1);
    quiet_flush();
    for (int d = 0; d < 2; d++)
      while (pending(d) != 0) begin
        pop_pair(d, a, e); checks++;
        if (a !== e) begin errors++; $display("FAIL timeout dut%0d event: got %h expected %h", d, a, e); end
      end
  endtask

  task automatic test_enable();
    logic [63:0] a, e;
    toggle_after(2);
    repeat (4) toggle_after(10);
    repeat (5) @(negedge i_Clk);
    checks += 2;
    if (locked0 !== 1'b1) begin errors++; $display("FAIL enable_prelock locked0: got %b expected 1", locked0); end
    if (locked1 !== 1'b1) begin errors++; $display("FAIL enable_prelock locked1: got %b expected 1", locked1); end
    i_Enable = 1'b0;
    model_disable();
    @(negedge i_Clk);
    checks += 2;
    if ({locked0, match0} !== 2'b00) begin errors++; $display("FAIL enable_off dut0 locked/match: got %b expected 00", {locked0, match0}); end
    if ({locked1, match1} !== 2'b00) begin errors++; $display("FAIL enable_off dut1 locked/match: got %b expected 00", {locked1, match1}); end
    repeat (2) @(negedge i_Clk);
    i_Enable = 1'b1;
    toggle_after(3);
    toggle_after(10);
    quiet_flush();
    for (int d = 0; d < 2; d++)
      while (pending(d) != 0) begin
        pop_pair(d, a, e); checks++;
        if (a !== e) begin errors++; $display("FAIL enable dut%0d event: got %h expected %h", d, a, e); end
      end
  endtask

  task automatic test_async_reset();
    logic [63:0] a, e;
    toggle_after(2);
    repeat (4) toggle_after(10);
    repeat (9) @(negedge i_Clk);
    #2 i_Rst = 1'b1;
    #1;
    checks += 2;
    if ({period0 != '0, valid0, match0, locked0, tmo0} !== 5'b0) begin errors++; $display("FAIL async_reset dut0 outputs: got p=%0d v%b m%b l%b t%b expected all 0", period0, valid0, match0, locked0, tmo0); end
    if ({period1 != '0, valid1, match1, locked1, tmo1} !== 5'b0) begin errors++; $display("FAIL async_reset dut1 outputs: got p=%0d v%b m%b l%b t%b expected all 0", period1, valid1, match1, locked1, tmo1); end
    i_Toggle = 1'b0;
    model_reset();
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b0;
    toggle_after(4);
    toggle_after(10);
    quiet_flush();
    for (int d = 0; d < 2; d++)
      while (pending(d) != 0) begin
        pop_pair(d, a, e); checks++;
        if (a !== e) begin errors++; $display("FAIL async_reset dut%0d event: got %h expected %h", d, a, e); end
      end
  endtask

  task automatic test_random();
    logic [63:0] a, e;
    toggle_after(2);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) toggle_after(int'($urandom_range(38, 45)));
      else                           toggle_after(int'($urandom_range(7, 13)));
    end
    quiet_flush();
    for (int d = 0; d < 2; d++)
      while (pending(d) != 0) begin
        pop_pair(d, a, e); checks++;
        if (a !== e) begin errors++; $display("FAIL random dut%0d event: got %h expected %h", d, a, e); end
      end
  endtask

  initial begin
    test_reset();
    test_lock_and_tolerance();
    test_timeout();
    test_enable();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
